sha256_nonce_block_gen: RTL and testbench

- Upstream feeder for the first expander stage of the double-SHA256 mining pipeline.
- Accepts one mining job: the last three header words of block 2, plus a nonce range.
- Then issues one fully padded 512-bit message block per cycle, one per nonce, with `write_en`.
- Tags each block with its nonce so downstream hit logic can recover the winning nonce.

---
 rtl/sha256_nonce_block_gen_pkg.sv | 37 +++
 rtl/sha256_nonce_counter.sv | 50 +++++
 rtl/sha256_nonce_block_gen.sv | 169 ++++++++++++++++
 tb/tb_sha256_nonce_block_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_nonce_block_gen_pkg.sv
// Shared definitions for the double-SHA256 nonce block generator:
// word/block widths, default padding constants, the sweep FSM states,
// the block-2 header tail layout and a helper that assembles a padded block.
package sha256_pkg;

  localparam int unsigned SHA256_WORD_W  = 32;
  localparam int unsigned SHA256_BLOCK_W = 512;

  // w4 carries the single '1' padding bit, w15 the 640-bit message length.
  localparam logic [31:0] SHA256_PAD_WORD = 32'h80000000;
  localparam logic [31:0] SHA256_LEN_WORD = 32'h00000280;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Words w0..w3 of the second header block, w0 in the MSBs.
  typedef struct packed {
    logic [31:0] merkle_tail;
    logic [31:0] time_w;
    logic [31:0] bits;
    logic [31:0] nonce;
  } block2_t;

  // Assemble the full big-endian 512-bit block: header tail, pad word,
  // ten constant zero words (w5..w14) and the length word.
  function automatic logic [SHA256_BLOCK_W-1:0] build_block(
    input block2_t     b2,
    input logic [31:0] pad_word,
    input logic [31:0] len_word
  );
    return {b2, pad_word, 320'd0, len_word};
  endfunction

endpackage

// File: rtl/sha256_nonce_counter.sv
// Loadable nonce counter with modular step and exact-equality terminal
// detection. Kept separate so other sweep engines can reuse the same
// termination rule (sweep ends only when count equals the latched end).
module sha256_nonce_counter
  import sha256_pkg::*;
#(
  parameter logic [SHA256_WORD_W-1:0] STEP = 32'd1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     step,
  input  logic [SHA256_WORD_W-1:0] start_val,
  input  logic [SHA256_WORD_W-1:0] end_val,
  output logic [SHA256_WORD_W-1:0] count,
  output logic                     is_last
);

  logic [SHA256_WORD_W-1:0] count_d, count_q;
  logic [SHA256_WORD_W-1:0] end_d, end_q;

  // Next-count selection: load wins over step; addition wraps mod 2^32.
  always_comb begin
    count_d = count_q;
    end_d   = end_q;
    if (load) begin
      count_d = start_val;
      end_d   = end_val;
    end else if (step) begin
      count_d = count_q + STEP;
    end else begin
      count_d = count_q;
    end
  end

  // Counter and end-value registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
      end_q   <= 32'd0;
    end else begin
      count_q <= count_d;
      end_q   <= end_d;
    end
  end

  assign count   = count_q;
  assign is_last = (count_q == end_q);

endmodule

// File: rtl/sha256_nonce_block_gen.sv
// Nonce block generator feeding the first expander stage of the mining
// pipeline. Accepts one job (last three header words + nonce range) and
// issues one padded 512-bit block per unstalled cycle, tagged with its nonce.
// Optional feature macro: SHA256_NONCE_GEN_STATS_EN adds blocks_issued,
// a saturating count of write_en cycles for the current/last job.
module sha256_nonce_block_gen
  import sha256_pkg::*;
#(
  parameter logic [31:0] PAD_WORD   = SHA256_PAD_WORD,
  parameter logic [31:0] LEN_WORD   = SHA256_LEN_WORD,
  parameter logic [31:0] NONCE_STEP = 32'd1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [95:0]               job_data,
  input  logic [31:0]               nonce_start,
  input  logic [31:0]               nonce_end,
  input  logic                      stall,
  input  logic                      abort,
  output logic                      write_en,
  output logic [SHA256_BLOCK_W-1:0] block_out,
  output logic [31:0]               nonce_out,
`ifdef SHA256_NONCE_GEN_STATS_EN
  output logic [31:0]               blocks_issued,
`endif
  output logic                      busy,
  output logic                      done
);

  state_e                    state_d, state_q;
  logic [95:0]               job_d, job_q;
  logic                      write_en_d, write_en_q;
  logic [SHA256_BLOCK_W-1:0] block_d, block_q;
  logic [31:0]               nonce_out_d, nonce_out_q;
  logic                      busy_d, busy_q;
  logic                      done_d, done_q;
  logic                      job_ready_d, job_ready_q;
  logic                      handshake_s;
  logic                      ctr_load_s, ctr_step_s;
  logic [31:0]               ctr_count_s;
  logic                      ctr_is_last_s;
  block2_t                   b2_s;

  assign handshake_s = job_valid && job_ready_q;
  assign b2_s        = {job_q, ctr_count_s};

  sha256_nonce_counter #(
    .STEP (NONCE_STEP)
  ) u_counter (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (ctr_load_s),
    .step      (ctr_step_s),
    .start_val (nonce_start),
    .end_val   (nonce_end),
    .count     (ctr_count_s),
    .is_last   (ctr_is_last_s)
  );

  // Sweep FSM: job accept, per-cycle block issue, stall/abort handling.
  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    write_en_d  = 1'b0;
    block_d     = block_q;
    nonce_out_d = nonce_out_q;
    ctr_load_s  = 1'b0;
    ctr_step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) begin
          job_d      = job_data;
          ctr_load_s = 1'b1;
          state_d    = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Abort beats stall: no block this cycle, finish next cycle.
          state_d = ST_DONE;
        end else if (stall) begin
          state_d = ST_RUN;
        end else begin
          write_en_d  = 1'b1;
          nonce_out_d = ctr_count_s;
          block_d     = build_block(b2_s, PAD_WORD, LEN_WORD);
          if (ctr_is_last_s) begin
            state_d = ST_DONE;
          end else begin
            ctr_step_s = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Status outputs are registered views of the state being entered;
    // done follows the DONE cycle so it lands right after the last block.
    busy_d      = (state_d == ST_RUN);
    job_ready_d = (state_d == ST_IDLE);
    done_d      = (state_q == ST_DONE);
  end

  // State, job latch and registered output stage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      job_q       <= 96'd0;
      write_en_q  <= 1'b0;
      block_q     <= 512'd0;
      nonce_out_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      job_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      write_en_q  <= write_en_d;
      block_q     <= block_d;
      nonce_out_q <= nonce_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      job_ready_q <= job_ready_d;
    end
  end

`ifdef SHA256_NONCE_GEN_STATS_EN
  logic [31:0] blocks_d, blocks_q;

  // Issued-block counter: cleared per job, saturating, held after DONE.
  always_comb begin
    blocks_d = blocks_q;
    if (handshake_s) begin
      blocks_d = 32'd0;
    end else if (write_en_d && (blocks_q != 32'hFFFFFFFF)) begin
      blocks_d = blocks_q + 32'd1;
    end else begin
      blocks_d = blocks_q;
    end
  end

  // Issued-block counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      blocks_q <= 32'd0;
    end else begin
      blocks_q <= blocks_d;
    end
  end

  assign blocks_issued = blocks_q;
`endif

  assign job_ready = job_ready_q;
  assign write_en  = write_en_q;
  assign block_out = block_q;
  assign nonce_out = nonce_out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sha256_nonce_block_gen.sv
// Self-checking bench for sha256_nonce_block_gen: table of directed and
// random jobs checked against a nonce-sequence reference model, plus
// hand-written reset-state and reset-mid-sweep sequences.
module tb_sha256_nonce_block_gen;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [95:0]  job_data = 96'd0;
  logic [31:0]  nonce_start = 32'd0;
  logic [31:0]  nonce_end = 32'd0;
  logic         stall = 1'b0;
  logic         abort = 1'b0;
  logic         write_en;
  logic [511:0] block_out;
  logic [31:0]  nonce_out;
  logic         busy;
  logic         done;
`ifdef SHA256_NONCE_GEN_STATS_EN
  logic [31:0]  blocks_issued;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sha256_nonce_block_gen dut (
    .CLK         (CLK),
    .RST         (RST),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_data    (job_data),
    .nonce_start (nonce_start),
    .nonce_end   (nonce_end),
    .stall       (stall),
    .abort       (abort),
    .write_en    (write_en),
    .block_out   (block_out),
    .nonce_out   (nonce_out),
`ifdef SHA256_NONCE_GEN_STATS_EN
    .blocks_issued (blocks_issued),
`endif
    .busy        (busy),
    .done        (done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [95:0] data;
    logic [31:0] s;
    logic [31:0] e;
    int          stall_pct;
    int          stall_after;
    int          stall_len;
    int          abort_after;
    int          exp_blocks;   // -1: take the count from the model
  } vec_t;

  vec_t tbl[$];

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check512(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference block: sixteen 32-bit words, w0 first (big-endian packing).
  function automatic logic [511:0] exp_block(input logic [95:0] d, input logic [31:0] n);
    logic [31:0]  w [16];
    logic [511:0] b;
    for (int i = 0; i < 16; i++) w[i] = 32'h0;
    w[0]  = d[95:64];
    w[1]  = d[63:32];
    w[2]  = d[31:0];
    w[3]  = n;
    w[4]  = 32'h80000000;
    w[15] = 32'h00000280;
    b = 512'd0;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = w[i];
    return b;
  endfunction

  task automatic run_job(input vec_t v);
    logic [31:0]  exp_q[$];
    logic [31:0]  n;
    logic [31:0]  last_nonce;
    logic [511:0] last_blk;
    int           limit, want, got, cycles, last_we, abort_at, stall_left, budget, done_cnt;
    bit           aborting, stall_used, stall_s, abort_s;

    // Model: the nonces a full sweep visits, start..end inclusive, mod 2^32.
    n = v.s;
    for (int k = 0; k < 5000; k++) begin
      exp_q.push_back(n);
      if (n == v.e) break;
      n = n + 32'd1;
    end
    aborting = (v.abort_after >= 0) && (v.abort_after < exp_q.size());
    limit    = aborting ? v.abort_after : exp_q.size();
    want     = (v.exp_blocks >= 0) ? v.exp_blocks : limit;

    @(negedge CLK);
    check1("ready_before_job", job_ready, 1'b1);
    job_valid   = 1'b1;
    job_data    = v.data;
    nonce_start = v.s;
    nonce_end   = v.e;
    @(posedge CLK); #1;
    job_valid   = 1'b0;
    job_data    = {$urandom, $urandom, $urandom};
    nonce_start = $urandom;
    nonce_end   = $urandom;
    check1("busy_after_accept", busy, 1'b1);
    check1("ready_in_run", job_ready, 1'b0);
    check1("we_after_accept", write_en, 1'b0);
    check1("done_single_pulse", done, 1'b0);

    got = 0; cycles = 0; last_we = -1; abort_at = -1; stall_left = 0;
    done_cnt = 0; stall_used = 1'b0; last_nonce = 32'd0; last_blk = 512'd0;
    budget = 4 * limit + 60;
    while (done_cnt == 0 && cycles < budget) begin
      abort = 1'b0;
      stall = 1'b0;
      if (aborting && abort_at < 0 && got == v.abort_after) begin
        abort    = 1'b1;
        abort_at = cycles;
      end
      if (!stall_used && v.stall_after >= 0 && got == v.stall_after) begin
        stall_left = v.stall_len;
        stall_used = 1'b1;
      end
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else if (v.stall_pct > 0 && $urandom_range(0, 99) < v.stall_pct) begin
        stall = 1'b1;
      end
      stall_s = stall;
      abort_s = abort;
      @(posedge CLK); #1;
      cycles++;
      if (stall_s) check1("we_while_stalled", write_en, 1'b0);
      if (abort_s) check1("we_on_abort", write_en, 1'b0);
      if (cycles == 1 && v.stall_pct == 0 && v.stall_after != 0 && v.abort_after != 0)
        check1("first_block_latency", write_en, 1'b1);
      if (write_en) begin
        if (got >= limit) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_block: got nonce %h after %0d blocks, required none", nonce_out, got);
        end else begin
          last_nonce = exp_q[got];
          last_blk   = exp_block(v.data, exp_q[got]);
          check32("nonce_out", nonce_out, last_nonce);
          check512("block_out", block_out, last_blk);
          got++;
          last_we = cycles;
        end
      end else if (got > 0) begin
        check32("nonce_hold", nonce_out, last_nonce);
        check512("block_hold", block_out, last_blk);
      end
      if (done) begin
        done_cnt++;
        check1("busy_at_done", busy, 1'b0);
        if (abort_at >= 0) check32("abort_done_latency", cycles, abort_at + 2);
        else               check32("done_latency", cycles, last_we + 1);
      end
    end
    abort = 1'b0;
    stall = 1'b0;
    if (done_cnt == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, required one", budget);
    end
    check32("block_count", got, want);
    check1("ready_at_done", job_ready, 1'b1);
`ifdef SHA256_NONCE_GEN_STATS_EN
    check32("blocks_issued", blocks_issued, want);
`endif
  endtask

  initial begin
    vec_t v;

    // Directed jobs from the test plan.
    tbl.push_back('{96'h111111112222222233333333, 32'd5, 32'd7, 0, -1, 0, -1, 3});
    tbl.push_back('{96'hA5A5A5A5_0F0F0F0F_DEADBEEF, 32'hFFFFFFFE, 32'd1, 0, -1, 0, -1, 4});
    tbl.push_back('{96'h01020304_05060708_090A0B0C, 32'd0, 32'd9, 0, 4, 3, -1, 10});
    tbl.push_back('{96'hCAFEBABE_12345678_9ABCDEF0, 32'd0, 32'd1000, 25, -1, 0, 20, 20});
    tbl.push_back('{96'h0BADF00D_00000001_FFFFFFFF, 32'h100, 32'h102, 0, -1, 0, -1, 3});
    tbl.push_back('{96'h76543210_FEDCBA98_13579BDF, 32'h0000ABCD, 32'h0000ABCD, 0, -1, 0, -1, 1});
    // Random jobs, some straddling the 32-bit wrap, some aborted.
    for (int i = 0; i < 8; i++) begin
      v.data        = {$urandom, $urandom, $urandom};
      v.s           = (i % 2 == 0) ? $urandom : (32'hFFFFFFFF - $urandom_range(0, 10));
      v.e           = v.s + $urandom_range(0, 30);
      v.stall_pct   = 30;
      v.stall_after = -1;
      v.stall_len   = 0;
      v.abort_after = (i % 3 == 2) ? $urandom_range(0, 12) : -1;
      v.exp_blocks  = -1;
      tbl.push_back(v);
    end

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    check1("rst_job_ready", job_ready, 1'b1);
    check1("rst_write_en", write_en, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check32("rst_nonce_out", nonce_out, 32'd0);
    check512("rst_block_out", block_out, 512'd0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_job(tbl[i]);

    // Reset mid-sweep.
    @(negedge CLK);
    job_valid   = 1'b1;
    job_data    = 96'h1;
    nonce_start = 32'd0;
    nonce_end   = 32'd1000;
    @(posedge CLK); #1;
    job_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    check1("midsweep_busy_before", busy, 1'b1);
    RST = 1'b0;
    #1;
    check1("midsweep_write_en", write_en, 1'b0);
    check1("midsweep_busy", busy, 1'b0);
    check1("midsweep_done", done, 1'b0);
    check1("midsweep_job_ready", job_ready, 1'b1);
`ifdef SHA256_NONCE_GEN_STATS_EN
    check32("midsweep_blocks_issued", blocks_issued, 32'd0);
`endif
    @(posedge CLK); #1;
    check1("midsweep_no_done", done, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    run_job('{96'h76543210_FEDCBA98_13579BDF, 32'h0000ABCD, 32'h0000ABCD, 0, -1, 0, -1, 1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
